block_emitter: RTL and testbench
================================

Name: block_emitter

Overview:
- Generator side of the begin/end keyword stream: turns block commands (open block, close block, filler identifier) into an ASCII byte stream, one character per clock.
- Output matches the checker-side format: words separated by spaces, idle filler is a space.
- Tracks nesting depth and refuses commands that would unbalance the stream, so a downstream keyword checker always sees a legal stream.
- Used as the stimulus/source for the text-stream checker and in loop-back tests.

Parameters:
DEPTH_W, 8, width of the nesting-depth counter; maximum depth = 2^DEPTH_W - 1
LEN_W, 3, width of identifier length field; max identifier length = 2^LEN_W - 1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_op  input  2  00 BEGIN, 01 END, 10 IDENT, 11 reserved (accepted, rejected)
cmd_upper  input  1  1 = emit word in uppercase, 0 = lowercase
cmd_len  input  LEN_W  IDENT length in characters; 0 treated as 1; ignored for BEGIN/END
cmd_ready  output  1  command can be accepted this cycle (combinational from state)
out  output  8  ASCII character currently presented
out_valid  output  1  out carries a separator or word character (not idle filler)
depth  output  DEPTH_W  current open-block count
balanced  output  1  depth == 0 (combinational)
err  output  1  one-cycle pulse: previously accepted command was rejected

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE, out = 8'h20, out_valid = 0, depth = 0, err = 0; cmd_ready = 1 and balanced = 1 after reset.
- States: IDLE (out = space, out_valid = 0), SEP (out = space, out_valid = 1), CHAR (out = word[idx], out_valid = 1).
- Word table:
  - BEGIN = "begin", length 5.
  - END = "end", length 3.
  - IDENT = 'x' repeated max(cmd_len, 1) times.
  - cmd_upper selects the uppercase variant (e.g. 'B' 'E' 'G' 'I' 'N', 'X'); it is latched at acceptance.
- cmd_ready = (state == IDLE) || (state == CHAR && idx == len-1).
- Acceptance: cmd_valid && cmd_ready at a rising edge. The op, case and length are latched at that edge.
- Legality and depth, decided at the acceptance edge:
  - BEGIN with depth == max: rejected.
  - END with depth == 0: rejected.
  - op 11: rejected.
  - Legal BEGIN: depth + 1 at the same edge. Legal END: depth - 1 at the same edge. IDENT: no depth change.
  - Depth never wraps.
- Legal accept: next state SEP, out <= 8'h20. Latency: the separator appears the cycle after acceptance; the first word character appears 2 cycles after acceptance.
- Rejected accept:
  - next state IDLE, out <= 8'h20, out_valid <= 0, err <= 1 for exactly one cycle.
  - No characters are emitted and depth is unchanged.
- SEP -> CHAR with idx = 0.
- CHAR with idx < len-1: idx + 1.
- CHAR with idx == len-1:
  - legal accept -> SEP;
  - rejected accept -> IDLE with err;
  - no accept -> IDLE.
- Throughput: back-to-back commands produce a gap-free stream; each word occupies len+1 cycles (separator + characters).
- A leading separator is always emitted, including before the first word after reset.
- err defaults to 0 every cycle unless set by a rejection.
- cmd_valid while not ready is ignored; the command is neither latched nor counted, and the source holds it.
- Reset mid-word: the stream is truncated immediately; the next cycle shows space with out_valid = 0, and depth returns to 0.
- The emitted stream with all rejected commands removed is always a prefix of a balanced begin/end sequence.

Decomposition:
- Shared package block_stream_pkg:
  - op encodings (OP_BEGIN, OP_END, OP_IDENT);
  - ASCII constants (CH_SPACE, lowercase/uppercase b e g i n d x);
  - state encoding;
  - word-length constants LEN_BEGIN = 5, LEN_END = 3.
- One sub-module, block_word_rom: combinational (op, upper, idx) -> 8-bit character.
- Character selection stays out of the FSM.

Test Plan:
- Reset, then BEGIN lowercase at cycle 0 -> out ' ','b','e','g','i','n' at cycles 1-6 with out_valid = 1; depth = 1 from cycle 1; IDLE/space at cycle 7.
- BEGIN(upper) then END(upper) presented continuously -> " BEGIN END" gap-free over 10 cycles; cmd_ready high on the 'N' cycle; depth 0->1->0; balanced = 1 at end.
- END at depth 0 -> err = 1 for one cycle; out stays 8'h20 with out_valid = 0; depth stays 0.
- IDENT with cmd_len = 3 lowercase -> " xxx"; cmd_len = 0 -> " x"; depth unchanged.
- DEPTH_W = 2: four BEGINs -> first three emitted (depth 3); fourth rejected with err pulse; following END accepted, depth 2.
- Reset asserted on the 'g' of "begin" -> next cycle out = 8'h20, out_valid = 0, depth = 0, cmd_ready = 1.

Source files
------------

// File: rtl/block_stream_pkg.sv
// Shared definitions for the begin/end keyword stream: op codes, ASCII constants,
// emitter state encoding and fixed word lengths.
package block_stream_pkg;

    typedef enum logic [1:0] {
        OP_BEGIN = 2'b00,
        OP_END   = 2'b01,
        OP_IDENT = 2'b10,
        OP_RSVD  = 2'b11
    } block_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEP  = 2'b01,
        ST_CHAR = 2'b10
    } block_state_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B_LO  = 8'h62;
    localparam logic [7:0] CH_E_LO  = 8'h65;
    localparam logic [7:0] CH_G_LO  = 8'h67;
    localparam logic [7:0] CH_I_LO  = 8'h69;
    localparam logic [7:0] CH_N_LO  = 8'h6e;
    localparam logic [7:0] CH_D_LO  = 8'h64;
    localparam logic [7:0] CH_X_LO  = 8'h78;
    localparam logic [7:0] CH_B_UP  = 8'h42;
    localparam logic [7:0] CH_E_UP  = 8'h45;
    localparam logic [7:0] CH_G_UP  = 8'h47;
    localparam logic [7:0] CH_I_UP  = 8'h49;
    localparam logic [7:0] CH_N_UP  = 8'h4e;
    localparam logic [7:0] CH_D_UP  = 8'h44;
    localparam logic [7:0] CH_X_UP  = 8'h58;

    localparam int LEN_BEGIN = 5;
    localparam int LEN_END   = 3;

endpackage

// File: rtl/block_word_rom.sv
// Character lookup for the emitted words: (op, case, index) -> ASCII byte.
module block_word_rom
    import block_stream_pkg::*;
#(
    parameter int LEN_W = 3
) (
    input  block_op_e        op_i,
    input  logic             upper_i,
    input  logic [LEN_W-1:0] idx_i,
    output logic [7:0]       char_o
);

    logic [7:0] lo;
    logic [7:0] up;

    always_comb begin
        lo = CH_SPACE;
        up = CH_SPACE;
        case (op_i)
            OP_BEGIN: begin
                case (int'(idx_i))
                    0: begin lo = CH_B_LO; up = CH_B_UP; end
                    1: begin lo = CH_E_LO; up = CH_E_UP; end
                    2: begin lo = CH_G_LO; up = CH_G_UP; end
                    3: begin lo = CH_I_LO; up = CH_I_UP; end
                    4: begin lo = CH_N_LO; up = CH_N_UP; end
                    default: begin lo = CH_SPACE; up = CH_SPACE; end
                endcase
            end
            OP_END: begin
                case (int'(idx_i))
                    0: begin lo = CH_E_LO; up = CH_E_UP; end
                    1: begin lo = CH_N_LO; up = CH_N_UP; end
                    2: begin lo = CH_D_LO; up = CH_D_UP; end
                    default: begin lo = CH_SPACE; up = CH_SPACE; end
                endcase
            end
            OP_IDENT: begin
                lo = CH_X_LO;
                up = CH_X_UP;
            end
            default: begin
                lo = CH_SPACE;
                up = CH_SPACE;
            end
        endcase
        char_o = upper_i ? up : lo;
    end

endmodule

// File: rtl/block_emitter.sv
// Turns BEGIN/END/IDENT commands into a space-separated ASCII byte stream, one
// character per clock, refusing commands that would unbalance the nesting.
module block_emitter
    import block_stream_pkg::*;
#(
    parameter int DEPTH_W = 8,
    parameter int LEN_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic               cmd_upper,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic               cmd_ready,
    output logic [7:0]         out,
    output logic               out_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               err,
    output block_state_e       dbg_state_o
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    block_state_e     state_q, state_d;
    block_op_e        op_q, op_d;
    logic             upper_q, upper_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [7:0]       out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    block_op_e        cmd_op_e;
    logic             last_char;
    logic             accept;
    logic             legal;
    logic [LEN_W-1:0] cmd_len_eff;
    logic [7:0]       rom_char;

    assign cmd_op_e  = block_op_e'(cmd_op);
    assign last_char = (idx_q == LEN_W'(len_q - 1'b1));
    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_CHAR) && last_char);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        legal       = 1'b0;
        cmd_len_eff = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
        case (cmd_op_e)
            OP_BEGIN: begin
                legal       = (depth_q != DEPTH_MAX);
                cmd_len_eff = LEN_W'(LEN_BEGIN);
            end
            OP_END: begin
                legal       = (depth_q != '0);
                cmd_len_eff = LEN_W'(LEN_END);
            end
            OP_IDENT: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    // The ROM is addressed with the next index so the character lands in out_q
    // together with the CHAR state it belongs to.
    block_word_rom #(.LEN_W(LEN_W)) u_rom (
        .op_i    (op_q),
        .upper_i (upper_q),
        .idx_i   (idx_d),
        .char_o  (rom_char)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        upper_d     = upper_q;
        len_d       = len_q;
        idx_d       = idx_q;
        depth_d     = depth_q;
        out_d       = CH_SPACE;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        if (accept) begin
            idx_d = '0;
            if (legal) begin
                state_d     = ST_SEP;
                op_d        = cmd_op_e;
                upper_d     = cmd_upper;
                len_d       = cmd_len_eff;
                out_valid_d = 1'b1;
                if (cmd_op_e == OP_BEGIN) depth_d = depth_q + 1'b1;
                if (cmd_op_e == OP_END)   depth_d = depth_q - 1'b1;
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_SEP: begin
                    state_d     = ST_CHAR;
                    idx_d       = '0;
                    out_d       = rom_char;
                    out_valid_d = 1'b1;
                end
                ST_CHAR: begin
                    if (!last_char) begin
                        idx_d       = idx_q + 1'b1;
                        out_d       = rom_char;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_IDENT;
            upper_q     <= 1'b0;
            len_q       <= LEN_W'(1);
            idx_q       <= '0;
            depth_q     <= '0;
            out_q       <= CH_SPACE;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            upper_q     <= upper_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            depth_q     <= depth_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign depth       = depth_q;
    assign balanced    = (depth_q == '0);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_block_emitter.sv
// Directed bench for block_emitter: default-depth instance plus a DEPTH_W=2
// instance sharing the same command inputs for the depth-limit case.
module tb_block_emitter;
    import block_stream_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_upper;
    logic [2:0] cmd_len;

    logic         a_ready, a_valid, a_bal, a_err;
    logic [7:0]   a_out, a_depth;
    block_state_e a_state;
    logic         b_ready, b_valid, b_bal, b_err;
    logic [7:0]   b_out;
    logic [1:0]   b_depth;
    block_state_e b_state;

    logic         use_b;
    logic         s_ready, s_valid, s_bal, s_err;
    logic [7:0]   s_out, s_depth;
    block_state_e s_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    block_emitter #(.DEPTH_W(8), .LEN_W(3)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_upper(cmd_upper), .cmd_len(cmd_len), .cmd_ready(a_ready),
        .out(a_out), .out_valid(a_valid), .depth(a_depth), .balanced(a_bal),
        .err(a_err), .dbg_state_o(a_state)
    );

    block_emitter #(.DEPTH_W(2), .LEN_W(3)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_upper(cmd_upper), .cmd_len(cmd_len), .cmd_ready(b_ready),
        .out(b_out), .out_valid(b_valid), .depth(b_depth), .balanced(b_bal),
        .err(b_err), .dbg_state_o(b_state)
    );

    assign s_ready = use_b ? b_ready : a_ready;
    assign s_valid = use_b ? b_valid : a_valid;
    assign s_bal   = use_b ? b_bal   : a_bal;
    assign s_err   = use_b ? b_err   : a_err;
    assign s_out   = use_b ? b_out   : a_out;
    assign s_depth = use_b ? {6'b0, b_depth} : a_depth;
    assign s_state = use_b ? b_state : a_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(s_ready), 32'd1);
    endtask

    task automatic emit_word(input logic [1:0] op, input logic up, input logic [2:0] len,
                             input string w, input int exp_depth);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_upper = up;
        cmd_len   = len;
        wait_ready();
        tick();
        cmd_valid = 1'b0;
        check("sep_char", 32'(s_out), 32'h20);
        check("sep_valid", 32'(s_valid), 32'd1);
        check("sep_depth", 32'(s_depth), 32'(exp_depth));
        check("sep_bal", 32'(s_bal), (exp_depth == 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < w.len(); i++) begin
            tick();
            check($sformatf("%s_char%0d", w, i), 32'(s_out), 32'(w[i]));
            check($sformatf("%s_valid%0d", w, i), 32'(s_valid), 32'd1);
        end
        check("ready_last", 32'(s_ready), 32'd1);
    endtask

    task automatic reject(input logic [1:0] op, input int exp_depth);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_upper = 1'b0;
        cmd_len   = 3'd2;
        wait_ready();
        tick();
        cmd_valid = 1'b0;
        check("rej_err", 32'(s_err), 32'd1);
        check("rej_out", 32'(s_out), 32'h20);
        check("rej_valid", 32'(s_valid), 32'd0);
        check("rej_depth", 32'(s_depth), 32'(exp_depth));
        tick();
        check("rej_err_clr", 32'(s_err), 32'd0);
        check("rej_idle_valid", 32'(s_valid), 32'd0);
    endtask

    task automatic check_idle(input int exp_depth);
        tick();
        check("idle_out", 32'(s_out), 32'h20);
        check("idle_valid", 32'(s_valid), 32'd0);
        check("idle_ready", 32'(s_ready), 32'd1);
        check("idle_depth", 32'(s_depth), 32'(exp_depth));
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_upper = 1'b0; cmd_len = 3'd0;
        use_b = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out", 32'(s_out), 32'h20);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_depth", 32'(s_depth), 32'd0);
        check("rst_err", 32'(s_err), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_bal", 32'(s_bal), 32'd1);
        check("rst_state", 32'(s_state), 32'(ST_IDLE));

        // Single lowercase BEGIN, then back to idle.
        emit_word(OP_BEGIN, 1'b0, 3'd0, "begin", 1);
        check_idle(1);

        // Back-to-back uppercase BEGIN/END.
        do_reset();
        emit_word(OP_BEGIN, 1'b1, 3'd0, "BEGIN", 1);
        emit_word(OP_END, 1'b1, 3'd0, "END", 0);
        check_idle(0);
        check("bal_end", 32'(s_bal), 32'd1);

        // Illegal commands at depth 0.
        reject(OP_END, 0);
        reject(OP_RSVD, 0);

        // Identifiers, including zero length.
        emit_word(OP_IDENT, 1'b0, 3'd3, "xxx", 0);
        emit_word(OP_IDENT, 1'b0, 3'd0, "x", 0);
        emit_word(OP_IDENT, 1'b1, 3'd7, "XXXXXXX", 0);
        check_idle(0);

        // Depth limit on the 2-bit instance.
        use_b = 1'b1;
        do_reset();
        emit_word(OP_BEGIN, 1'b0, 3'd0, "begin", 1);
        emit_word(OP_BEGIN, 1'b0, 3'd0, "begin", 2);
        emit_word(OP_BEGIN, 1'b0, 3'd0, "begin", 3);
        reject(OP_BEGIN, 3);
        emit_word(OP_END, 1'b0, 3'd0, "end", 2);
        check_idle(2);
        use_b = 1'b0;

        // Reset in the middle of a word.
        do_reset();
        cmd_valid = 1'b1; cmd_op = OP_BEGIN; cmd_upper = 1'b0; cmd_len = 3'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_g", 32'(s_out), 32'h67);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_out", 32'(s_out), 32'h20);
        check("mid_valid", 32'(s_valid), 32'd0);
        check("mid_depth", 32'(s_depth), 32'd0);
        check("mid_ready", 32'(s_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
